drive_ramp_ctrl: RTL

Per-wheel motor command generator for the line-following car. Consumes the 2-bit drive mode from the tracker stage and the `stop` flag from the ultrasonic stage. Produces 10-bit PWM duty and a logical direction code for each wheel, applying a slew-rate limit and a safe reversal sequence (ramp to zero before any direction change). Its duty outputs feed the two `motor_pwm` instances directly; its direction outputs are mapped to the H-bridge pins in the top level.

---
 rtl/drive_pkg.sv | 54 +++++
 rtl/drive_ramp_wheel.sv | 79 +++++++
 rtl/drive_ramp_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared encodings and the mode-to-wheel-target table for the drive ramp controller.
// Pure declarations: no latency, no flow control.
package drive_pkg;

    typedef enum logic [1:0] {
        MODE_STRAIGHT = 2'b00,
        MODE_LEFT     = 2'b01,
        MODE_RIGHT    = 2'b10,
        MODE_BACK     = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_FWD   = 2'b01,
        DIR_REV   = 2'b10,
        DIR_BRAKE = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_REVERSING = 2'b01,
        ST_ESTOP     = 2'b10
    } wheel_state_t;

    typedef struct packed {
        dir_t       dir;
        logic [9:0] duty;
    } target_t;

    localparam logic [10:0] DUTY_MAX = 11'd1023;

    function automatic target_t mode_target(input mode_t mode, input logic is_left,
                                            input logic [9:0] fast_duty,
                                            input logic [9:0] slow_duty);
        target_t t;
        t.dir  = DIR_FWD;
        t.duty = fast_duty;
        case (mode)
            MODE_LEFT:  if (is_left)  t.duty = slow_duty;
            MODE_RIGHT: if (!is_left) t.duty = slow_duty;
            MODE_BACK: begin
                t.dir  = DIR_REV;
                t.duty = slow_duty;
            end
            default: t.duty = fast_duty;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] clamp10(input logic [10:0] v);
        return (v > DUTY_MAX) ? 10'd1023 : v[9:0];
    endfunction

endpackage

// File: rtl/drive_ramp_wheel.sv
// One wheel: RUN/REVERSING/ESTOP FSM with registered duty and direction.
// Duty/dir update one edge after a tick (stop: one edge, tick-independent); no backpressure.
module drive_ramp_wheel
    import drive_pkg::*;
#(
    parameter logic [10:0] STEP = 11'd32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       stop,
    input  target_t    target,
    output logic [9:0] duty,
    output dir_t       dir,
    output logic       on_target
);

    wheel_state_t state, state_nxt;
    logic [9:0]   duty_nxt;
    dir_t         dir_nxt;
    logic [10:0]  duty_w, tgt_w, dec_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REVERSING;
            duty  <= '0;
            dir   <= DIR_BRAKE;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        duty_w    = {1'b0, duty};
        tgt_w     = {1'b0, target.duty};
        dec_w     = (duty_w > STEP) ? duty_w - STEP : 11'd0;
        state_nxt = state;
        duty_nxt  = duty;
        dir_nxt   = dir;
        if (stop) begin
            state_nxt = ST_ESTOP;
            duty_nxt  = '0;
            dir_nxt   = DIR_BRAKE;
        end else begin
            case (state)
                ST_ESTOP: state_nxt = ST_REVERSING;
                ST_REVERSING: begin
                    if (tick) begin
                        // Direction only ever changes on a tick that finds duty already at zero.
                        if (duty == '0) begin
                            dir_nxt   = target.dir;
                            state_nxt = ST_RUN;
                        end else begin
                            duty_nxt = clamp10(dec_w);
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (target.dir != dir) begin
                            state_nxt = ST_REVERSING;
                            duty_nxt  = clamp10(dec_w);
                        end else if (tgt_w > duty_w) begin
                            duty_nxt = clamp10((tgt_w - duty_w > STEP) ? duty_w + STEP : tgt_w);
                        end else begin
                            duty_nxt = clamp10((duty_w - tgt_w > STEP) ? duty_w - STEP : tgt_w);
                        end
                    end
                end
                default: state_nxt = ST_REVERSING;
            endcase
        end
    end

    assign on_target = (state == ST_RUN) && (duty == target.duty) && (dir == target.dir);

endmodule

// File: rtl/drive_ramp_ctrl.sv
// Two-wheel slew-limited motor command generator; DRIVE_RAMP_EN selects ramping, else full step every cycle.
// Outputs registered, 1 edge after a tick (stop: 1 edge always); no backpressure.
module drive_ramp_ctrl
    import drive_pkg::*;
#(
    parameter logic [9:0]  FAST_DUTY = 10'd1023,
    parameter logic [9:0]  SLOW_DUTY = 10'd512,
    parameter int unsigned RAMP_DIV  = 100_000,
    parameter logic [9:0]  RAMP_STEP = 10'd32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       stop,
    output logic [9:0] left_duty,
    output logic [9:0] right_duty,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic       settled
);

`ifdef DRIVE_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam logic [10:0] STEP_EFF = RAMP_EN ? {1'b0, RAMP_STEP} : DUTY_MAX;
    localparam int unsigned CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    target_t          l_tgt, r_tgt;
    dir_t             l_dir, r_dir;
    logic             l_ok, r_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // With ramping disabled every edge is a tick and the step covers the full range.
    assign tick  = !RAMP_EN || (cnt == CNT_LAST);
    assign l_tgt = mode_target(mode_t'(mode), 1'b1, FAST_DUTY, SLOW_DUTY);
    assign r_tgt = mode_target(mode_t'(mode), 1'b0, FAST_DUTY, SLOW_DUTY);

    drive_ramp_wheel #(.STEP(STEP_EFF)) u_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .stop      (stop),
        .target    (l_tgt),
        .duty      (left_duty),
        .dir       (l_dir),
        .on_target (l_ok)
    );

    drive_ramp_wheel #(.STEP(STEP_EFF)) u_right (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .stop      (stop),
        .target    (r_tgt),
        .duty      (right_duty),
        .dir       (r_dir),
        .on_target (r_ok)
    );

    assign left_dir  = l_dir;
    assign right_dir = r_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settled <= 1'b0;
        end else begin
            settled <= l_ok && r_ok;
        end
    end

endmodule
